// File: rtl/button_gesture.sv
// Gesture classifier for a debounced button. It turns press and hold activity into
// single-cycle short-press, double-click, long-press and auto-repeat events.
module button_gesture #(
   parameter int LONG_TICKS   = 50_000_000,
   parameter int DOUBLE_TICKS = 15_000_000,
   parameter int REPEAT_TICKS = 10_000_000,
   parameter int CNT_W        = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic pressed_i,
   input  logic held_i,
   output logic short_press_o,
   output logic double_click_o,
   output logic long_press_o,
   output logic repeat_o,
   output logic busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS1,
      WAIT2,
      PRESS2,
      LONG
   } state_e;

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;

   // NOTE: every register here is written with <= so all of them update on the same
   // edge from the values they held before it. Mixing in = would make the order of
   // statements change behaviour.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         short_press_o  <= 1'b0;
         double_click_o <= 1'b0;
         long_press_o   <= 1'b0;
         repeat_o       <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         short_press_o  <= 1'b0;
         double_click_o <= 1'b0;
         long_press_o   <= 1'b0;
         repeat_o       <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (pressed_i) begin
                  state_q <= PRESS1;
                  cnt_q   <= '0;
                  busy_o  <= 1'b1;
               end
            end
            // Release is tested before the threshold, so a release that lands on the
            // threshold cycle suppresses the long press.
            PRESS1: begin
               if (!held_i) begin
                  state_q <= WAIT2;
                  cnt_q   <= '0;
               end else if (cnt_q == LONG_LAST) begin
                  state_q      <= LONG;
                  cnt_q        <= '0;
                  long_press_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT2: begin
               if (pressed_i) begin
                  state_q        <= PRESS2;
                  cnt_q          <= '0;
                  double_click_o <= 1'b1;
               end else if (cnt_q == DOUBLE_LAST) begin
                  state_q       <= IDLE;
                  cnt_q         <= '0;
                  short_press_o <= 1'b1;
                  busy_o        <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // No interval is timed during the second press, so the counter stays at
            // zero and cannot wrap however long the button is held.
            PRESS2: begin
               if (!held_i) begin
                  state_q <= IDLE;
                  busy_o  <= 1'b0;
               end
            end
            LONG: begin
               if (!held_i) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_o  <= 1'b0;
               end else if (cnt_q == REPEAT_LAST) begin
                  cnt_q    <= '0;
                  repeat_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
